sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like slave port between NUM_MASTERS masters.
// A combinational grant (round-robin or fixed priority) selects the master
// driving the slave request; an address that stalls holds the grant (lock)
// until accepted. Accepted master IDs go into an in-order FIFO so that each
// slave data return is routed back to the master that issued it.
module sram_arbiter #(
   parameter  int NUM_MASTERS     = 2,
   parameter  int MAX_OUTSTANDING = 4,
   parameter  int RR_MODE         = 1,
   localparam int IDW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int PW              = $clog2(MAX_OUTSTANDING),
   localparam int CW              = PW + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_MASTERS-1:0]     m_req,
   input  logic [NUM_MASTERS-1:0]     m_wr,
   input  logic [2*NUM_MASTERS-1:0]   m_size,
   input  logic [32*NUM_MASTERS-1:0]  m_addr,
   input  logic [4*NUM_MASTERS-1:0]   m_wstrb,
   input  logic [32*NUM_MASTERS-1:0]  m_wdata,
   output logic [NUM_MASTERS-1:0]     m_addrok,
   output logic [NUM_MASTERS-1:0]     m_dataok,
   output logic [31:0]                m_rdata,
   output logic                       s_req,
   output logic                       s_wr,
   output logic [1:0]                 s_size,
   output logic [31:0]                s_addr,
   output logic [3:0]                 s_wstrb,
   output logic [31:0]                s_wdata,
   input  logic                       s_addrok,
   input  logic                       s_dataok,
   input  logic [31:0]                s_rdata,
   output logic [CW-1:0]              outstanding,
   output logic                       err_dataok
);

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] lock_id;
   logic           locked;
   logic [IDW-1:0] gnt_id;
   logic           gnt_vld;

   logic [IDW-1:0] id_mem [MAX_OUTSTANDING];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           fifo_full;
   logic           fifo_empty;
   logic           accept;
   logic           pop;
   logic [IDW-1:0] head_id;
   logic           err_q;

   // Next round-robin start point: one past the winner, wrapping at N-1.
   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
      logic [IDW:0] s;
      s = {1'b0, v} + (IDW+1)'(1);
      if (s >= (IDW+1)'(NUM_MASTERS)) s = '0;
      return s[IDW-1:0];
   endfunction

   assign fifo_full   = (count == CW'(MAX_OUTSTANDING));
   assign fifo_empty  = (count == '0);
   assign accept      = s_req & s_addrok;
   assign pop         = s_dataok & ~fifo_empty;
   assign head_id     = id_mem[rd_ptr];
   assign m_rdata     = s_rdata;
   assign outstanding = count;
   assign err_dataok  = err_q;

   // Grant selection: a held lock wins, otherwise round-robin from rr_ptr or lowest index.
   always_comb begin
      logic [IDW:0]   sum;
      logic [IDW-1:0] cand;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      sum     = '0;
      cand    = '0;
      if (locked) begin
         // A dropped request under lock leaves no grant, so nothing is issued.
         gnt_id  = lock_id;
         gnt_vld = m_req[lock_id];
      end else if (RR_MODE != 0) begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NUM_MASTERS)) sum = sum - (IDW+1)'(NUM_MASTERS);
            cand = sum[IDW-1:0];
            if (!gnt_vld && m_req[cand]) begin
               gnt_vld = 1'b1;
               gnt_id  = cand;
            end
         end
      end else begin
         for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = IDW'(i);
            if (!gnt_vld && m_req[cand]) begin
               gnt_vld = 1'b1;
               gnt_id  = cand;
            end
         end
      end
   end

   // Slave request fields are muxed from the granted master; zero without a grant.
   always_comb begin
      s_req   = gnt_vld & ~fifo_full;
      s_wr    = 1'b0;
      s_size  = '0;
      s_addr  = '0;
      s_wstrb = '0;
      s_wdata = '0;
      if (gnt_vld) begin
         s_wr    = m_wr[gnt_id];
         s_size  = m_size[2*gnt_id +: 2];
         s_addr  = m_addr[32*gnt_id +: 32];
         s_wstrb = m_wstrb[4*gnt_id +: 4];
         s_wdata = m_wdata[32*gnt_id +: 32];
      end
   end

   // Per-master handshakes: address accept to the granted master, data return to the FIFO head.
   always_comb begin
      m_addrok = '0;
      m_dataok = '0;
      if (accept) m_addrok[gnt_id] = 1'b1;
      if (pop)    m_dataok[head_id] = 1'b1;
   end

   // Control state: lock, round-robin pointer, FIFO pointers/occupancy, sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr  <= '0;
         lock_id <= '0;
         locked  <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (locked && !m_req[lock_id]) begin
            locked <= 1'b0;
         end else if (accept) begin
            locked <= 1'b0;
         end else if (s_req && !s_addrok) begin
            locked  <= 1'b1;
            lock_id <= gnt_id;
         end

         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (RR_MODE != 0) rr_ptr <= wrap_inc(gnt_id);
         end

         if (pop) rd_ptr <= rd_ptr + PW'(1);

         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         if (s_dataok && fifo_empty) err_q <= 1'b1;
      end
   end

   // ID storage: only the pointers need reset, the entries are written before use.
   always_ff @(posedge clk) begin
      if (accept) id_mem[wr_ptr] <= gnt_id;
   end

endmodule
